// File: rtl/circ_queue_pkg.sv
// Shared types and helpers for the circular queue: wrap-pointer struct and advance function.
package circ_queue_pkg;

  // Widest supported index; module instances use the low PTR_W bits.
  localparam int PTR_MAX_W = 16;

  typedef struct packed {
    logic                 phase;
    logic [PTR_MAX_W-1:0] idx;
  } wrap_ptr_t;

  // Next {phase, index}: last slot wraps to 0 and flips phase, so depth need not be a power of two.
  function automatic wrap_ptr_t ptr_advance(input wrap_ptr_t cur, input int depth);
    wrap_ptr_t nxt;
    if (32'(cur.idx) == 32'(depth - 1)) begin
      nxt.phase = ~cur.phase;
      nxt.idx   = '0;
    end else begin
      nxt.phase = cur.phase;
      nxt.idx   = cur.idx + PTR_MAX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/queue_wrap_ptr.sv
// Phase + index wrap counter for the queue head or tail; clear wins over advance.
module queue_wrap_ptr
  import circ_queue_pkg::*;
#(
  parameter int DEPTH = 40,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  output logic [PTR_W:0] ptr
);

  wrap_ptr_t cur;
  wrap_ptr_t nxt;
  logic      unused_hi;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cur                = '0;
    cur.phase          = ptr[PTR_W];
    cur.idx[PTR_W-1:0] = ptr[PTR_W-1:0];
    nxt                = ptr_advance(cur, DEPTH);
  end

  // Upper index bits are always zero for this depth.
  assign unused_hi = ^nxt.idx[PTR_MAX_W-1:PTR_W];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= {nxt.phase, nxt.idx[PTR_W-1:0]};
    end
  end

endmodule

// File: rtl/circ_queue_ctrl.sv
// Circular-buffer queue with valid/ready on both sides and any depth >= 2.
// Optional zero-latency empty-queue bypass when CIRC_QUEUE_BYPASS_EN is defined.
module circ_queue_ctrl
  import circ_queue_pkg::*;
#(
  parameter int DEPTH  = 40,
  parameter int DATA_W = 64,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [DATA_W-1:0] enq_data_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [DATA_W-1:0] deq_data_o,
  output logic [PTR_W:0]    head_ptr_o,
  output logic [PTR_W:0]    tail_ptr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_idx;
  logic [PTR_W-1:0]  tail_idx;
  logic              empty;
  logic              full;
  logic              enq_fire;
  logic              deq_fire;
  logic              mem_wr;
  logic              head_adv;

  assign head_idx = head_ptr_o[PTR_W-1:0];
  assign tail_idx = tail_ptr_o[PTR_W-1:0];

  assign empty = (head_ptr_o == tail_ptr_o);
  assign full  = (head_idx == tail_idx) && (head_ptr_o[PTR_W] != tail_ptr_o[PTR_W]);

  assign empty_o     = empty;
  assign full_o      = full;
  assign enq_ready_o = !full;

  assign enq_fire = enq_valid_i & enq_ready_o;
  assign deq_fire = deq_valid_o & deq_ready_i;

`ifdef CIRC_QUEUE_BYPASS_EN
  // An empty queue forwards the producer's entry; if taken, storage is left untouched.
  logic bypass;
  assign bypass      = empty & enq_valid_i;
  assign deq_valid_o = !flush_i && (!empty || enq_valid_i);
  assign deq_data_o  = bypass ? enq_data_i : mem[head_idx];
  assign mem_wr      = enq_fire && !flush_i && !(bypass && deq_ready_i);
  assign head_adv    = deq_fire && !flush_i && !bypass;
`else
  assign deq_valid_o = !empty;
  assign deq_data_o  = mem[head_idx];
  assign mem_wr      = enq_fire && !flush_i;
  assign head_adv    = deq_fire && !flush_i;
`endif

  queue_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .adv (head_adv),
    .ptr (head_ptr_o)
  );

  queue_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .adv (mem_wr),
    .ptr (tail_ptr_o)
  );

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[tail_idx] <= enq_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_o <= '0;
    end else if (mem_wr && !head_adv) begin
      count_o <= count_o + CNT_W'(1);
    end else if (head_adv && !mem_wr) begin
      count_o <= count_o - CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clk) disable iff (rst) count_o <= DEPTH_CNT);
  a_no_enq_full: assert property (@(posedge clk) disable iff (rst) full |-> !mem_wr);
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) empty |-> !head_adv);
`endif

endmodule

// File: tb/tb_circ_queue_ctrl.sv
// Self-checking bench for circ_queue_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_circ_queue_ctrl;

  localparam int DEPTH  = 40;
  localparam int DATA_W = 64;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [DATA_W-1:0] enq_data_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [DATA_W-1:0] deq_data_o;
  logic [PTR_W:0]    head_ptr_o;
  logic [PTR_W:0]    tail_ptr_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;

  circ_queue_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_data_i  (enq_data_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_data_o  (deq_data_o),
    .head_ptr_o  (head_ptr_o),
    .tail_ptr_o  (tail_ptr_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: contents as a queue, pointers as absolute positions modulo 2*DEPTH.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] deq_log[$];
  int m_head = 0;
  int m_tail = 0;

  function automatic logic [PTR_W:0] to_ptr(input int pos);
    return {1'(pos / DEPTH), PTR_W'(pos % DEPTH)};
  endfunction

  task automatic check_outputs();
    int          n;
    bit          exp_dv;
    logic [63:0] exp_dd;
    n      = mq.size();
    exp_dv = (n > 0);
    exp_dd = (n > 0) ? mq[0] : '0;
`ifdef CIRC_QUEUE_BYPASS_EN
    if (n == 0 && enq_valid_i) begin
      exp_dv = 1'b1;
      exp_dd = enq_data_i;
    end
    if (flush_i) exp_dv = 1'b0;
`endif
    check("count", 64'(count_o), 64'(n));
    check("full", 64'(full_o), 64'(n == DEPTH));
    check("empty", 64'(empty_o), 64'(n == 0));
    check("enq_ready", 64'(enq_ready_o), 64'(n < DEPTH));
    check("deq_valid", 64'(deq_valid_o), 64'(exp_dv));
    if (exp_dv) check("deq_data", deq_data_o, exp_dd);
    check("head_ptr", 64'(head_ptr_o), 64'(to_ptr(m_head)));
    check("tail_ptr", 64'(tail_ptr_o), 64'(to_ptr(m_tail)));
  endtask

  // One clock: drive at negedge, check pre-edge outputs, step the model at posedge.
  task automatic cycle(input bit r, input bit f, input bit ev, input logic [63:0] d, input bit dr);
    bit ef;
    bit df;
    rst         = r;
    flush_i     = f;
    enq_valid_i = ev;
    enq_data_i  = d;
    deq_ready_i = dr;
    #1;
    check_outputs();
    ef = ev && (mq.size() < DEPTH);
    df = dr && (mq.size() > 0);
    @(posedge clk);
    if (r || f) begin
      mq.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
`ifdef CIRC_QUEUE_BYPASS_EN
      if (mq.size() == 0 && ev && dr) begin
        deq_log.push_back(d);
        ef = 1'b0;
      end
`endif
      if (df) begin
        deq_log.push_back(mq.pop_front());
        m_head = (m_head + 1) % (2 * DEPTH);
      end
      if (ef) begin
        mq.push_back(d);
        m_tail = (m_tail + 1) % (2 * DEPTH);
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          ev;
    logic [63:0] d;
    bit          dr;
    bit          fl;
    int          cnt;
    bit          emp;
    bit          ful;
    bit          dv;
    logic [63:0] dd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int next_send;
    bit will_fire;
    bit seen_39;
    bit seen_wrap;
    bit seen_zero;

    // ev, data, deq_ready, flush -> count, empty, full, deq_valid, deq_data after the edge
    vecs[0] = '{1'b1, 64'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 64'hA1};
    vecs[1] = '{1'b1, 64'hA2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 64'hA1};
    vecs[2] = '{1'b1, 64'hA3, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 64'hA2};
    vecs[3] = '{1'b0, 64'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 64'hA3};
    vecs[4] = '{1'b0, 64'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 64'hA3};
    vecs[5] = '{1'b1, 64'hA4, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 64'h00};
    vecs[6] = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'h00};
    vecs[7] = '{1'b1, 64'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 64'hA5};
    vecs[8] = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'h00};

    rst = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; enq_data_i = '0; deq_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("rst_deq_valid", 64'(deq_valid_o), 64'd0);
    check("rst_head", 64'(head_ptr_o), 64'd0);
    check("rst_tail", 64'(tail_ptr_o), 64'd0);
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      enq_valid_i = vecs[i].ev; enq_data_i = vecs[i].d;
      deq_ready_i = vecs[i].dr; flush_i = vecs[i].fl;
      @(posedge clk);
      #1;
      enq_valid_i = 1'b0; deq_ready_i = 1'b0; flush_i = 1'b0;
      #1;
      check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 64'(empty_o), 64'(vecs[i].emp));
      check($sformatf("vec%0d_full", i), 64'(full_o), 64'(vecs[i].ful));
      check($sformatf("vec%0d_deq_valid", i), 64'(deq_valid_o), 64'(vecs[i].dv));
      if (vecs[i].dv) check($sformatf("vec%0d_deq_data", i), deq_data_o, vecs[i].dd);
      @(negedge clk);
    end
    // Table leaves the queue empty with both pointers at position 1.
    m_head = 1; m_tail = 1; mq.delete();
    cycle(1, 0, 0, 0, 0);

    // Fill to capacity, then one rejected enqueue
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 64'(i), 0);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_enq_ready", 64'(enq_ready_o), 64'd0);
    check("fill_count", 64'(count_o), 64'd40);
    check("fill_tail", 64'(tail_ptr_o), 64'h40);
    cycle(0, 0, 1, 64'd999, 0);
    check("fill_reject_count", 64'(count_o), 64'd40);
    check("fill_reject_tail", 64'(tail_ptr_o), 64'h40);
    cycle(1, 0, 0, 0, 0);

    // Random stalls, 100 entries in order across pointer wrap
    deq_log.delete();
    next_send = 0; seen_39 = 0; seen_wrap = 0; seen_zero = 0;
    for (int c = 0; c < 3000 && deq_log.size() < 100; c++) begin
      bit ev;
      bit dr;
      ev = (next_send < 100) && ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      will_fire = ev && (mq.size() < DEPTH);
      cycle(0, 0, ev, 64'(next_send), dr);
      if (will_fire) next_send++;
      if (head_ptr_o == 7'h27) seen_39 = 1;
      if (seen_39 && head_ptr_o == 7'h40) seen_wrap = 1;
      if (seen_wrap && head_ptr_o == 7'h00) seen_zero = 1;
    end
    check("stream_len", 64'(deq_log.size()), 64'd100);
    for (int i = 0; i < deq_log.size() && i < 100; i++)
      check($sformatf("stream_item%0d", i), deq_log[i], 64'(i));
    check("stream_seen_0_39", 64'(seen_39), 64'd1);
    check("stream_seen_1_0", 64'(seen_wrap), 64'd1);
    check("stream_seen_0_0", 64'(seen_zero), 64'd1);
    cycle(1, 0, 0, 0, 0);

    // Simultaneous enq/deq at count 1
    deq_log.delete();
    cycle(0, 0, 1, 64'd500, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 64'(501 + i), 1);
    check("simul_count", 64'(count_o), 64'd1);
    check("simul_head", 64'(head_ptr_o), 64'd10);
    check("simul_tail", 64'(tail_ptr_o), 64'd11);
    check("simul_len", 64'(deq_log.size()), 64'd10);
    for (int i = 0; i < deq_log.size() && i < 10; i++)
      check($sformatf("simul_item%0d", i), deq_log[i], 64'(500 + i));
    cycle(1, 0, 0, 0, 0);

    // Flush at count 17 together with an enqueue
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, 64'(1000 + i), 0);
    check("flush_pre_count", 64'(count_o), 64'd17);
    cycle(0, 1, 1, 64'hDEAD, 0);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_empty", 64'(empty_o), 64'd1);
    check("flush_head", 64'(head_ptr_o), 64'd0);
    check("flush_tail", 64'(tail_ptr_o), 64'd0);
    deq_log.delete();
    cycle(0, 0, 1, 64'h77, 0);
    cycle(0, 0, 0, 0, 1);
    check("flush_after_len", 64'(deq_log.size()), 64'd1);
    if (deq_log.size() > 0) check("flush_after_data", deq_log[0], 64'h77);

    // Reset mid-stream at count 25
    for (int i = 0; i < 25; i++) cycle(0, 0, 1, 64'(2000 + i), 0);
    cycle(1, 0, 0, 0, 0);
    check("rst2_count", 64'(count_o), 64'd0);
    check("rst2_empty", 64'(empty_o), 64'd1);
    check("rst2_deq_valid", 64'(deq_valid_o), 64'd0);
    check("rst2_head", 64'(head_ptr_o), 64'd0);
    check("rst2_tail", 64'(tail_ptr_o), 64'd0);
    cycle(0, 0, 1, 64'hAB, 0);
    check("rst2_first_valid", 64'(deq_valid_o), 64'd1);
    check("rst2_first_data", deq_data_o, 64'hAB);
    cycle(0, 0, 0, 0, 1);

    // Empty queue, enqueue 0x55 with consumer ready
    enq_valid_i = 1'b1; enq_data_i = 64'h55; deq_ready_i = 1'b1;
    #1;
`ifdef CIRC_QUEUE_BYPASS_EN
    check("byp_same_valid", 64'(deq_valid_o), 64'd1);
    check("byp_same_data", deq_data_o, 64'h55);
`else
    check("byp_same_valid", 64'(deq_valid_o), 64'd0);
`endif
    cycle(0, 0, 1, 64'h55, 1);
`ifdef CIRC_QUEUE_BYPASS_EN
    check("byp_next_count", 64'(count_o), 64'd0);
`else
    check("byp_next_count", 64'(count_o), 64'd1);
    check("byp_next_valid", 64'(deq_valid_o), 64'd1);
    check("byp_next_data", deq_data_o, 64'h55);
`endif
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
